disp_refresh_sequencer: RTL and testbench
=========================================

Name: disp_refresh_sequencer

Overview:
- Scheduler for the 4-digit 7-segment refresh path.
- Holds a double-buffered frame of four BCD digits plus a colon, and steps through digits 0..3.
- For each digit it drives the code, colon and digit index to the segment encoder, then starts one transfer of the 74HC595 shift engine and waits for its completion.
- It holds each digit for a fixed dwell and PWM-blanks the 595 output enable for brightness control. It replaces the free-running per-clock digit index in the clock top.

Parameters:
- PHASE_CYCLES, 1250: clocks per brightness phase. Dwell is 8 phases = 8*PHASE_CYCLES clocks per digit.
- TIMEOUT_CYCLES, 255: maximum clocks to wait for sr_done_i before declaring a fault.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- frame_load_i  input  1  one-cycle strobe; capture frame_digits_i, frame_colon_i and brightness_i into the pending buffer
- frame_digits_i  input  16  four BCD codes; digit0 = [3:0] ... digit3 = [15:12]; code 10 = blank
- frame_colon_i  input  1  colon state for the frame
- brightness_i  input  3  0 = 1/8 duty ... 7 = full duty
- sr_done_i  input  1  one-cycle pulse from the shift engine when a transfer has been latched
- sr_start_o  output  1  one-cycle pulse requesting a 16-bit shift-and-latch
- digit_code_o  output  4  BCD code of the current digit
- digit_sel_o  output  2  current digit index
- colon_o  output  1  colon for the current frame
- blank_o  output  1  high = displays dark; drives the 595 /OE
- frame_done_o  output  1  one-cycle pulse when digit 3 dwell ends
- fault_o  output  1  sticky; set on shift timeout

Behaviour:
- Reset (async, effective immediately, including mid-operation):
  - state = LOAD; digit_sel_o = 0.
  - Active and pending digits = 10; colon = 0; brightness = 7; pending_valid = 0.
  - Outputs: sr_start_o = 0, digit_code_o = 10, colon_o = 0, blank_o = 1, frame_done_o = 0, fault_o = 0.
  - All counters = 0.
- Pending buffer:
  - Written on every cycle with frame_load_i = 1; sets pending_valid.
  - Multiple loads within a frame: last one wins.
- LOAD (1 cycle):
  - If digit_sel_o == 0 and pending_valid: copy pending to active (digits, colon, brightness) and clear pending_valid.
  - If frame_load_i is asserted in this same cycle: the old pending is copied, the new value lands in pending, and pending_valid stays 1, so it applies next frame.
  - Register digit_code_o = active[digit_sel_o] and colon_o = active colon.
  - blank_o = 1. Go to START.
- START (1 cycle):
  - sr_start_o = 1; blank_o = 1.
  - Clear the timeout counter. Go to SHIFT.
- SHIFT:
  - blank_o = 1; the timeout counter increments each cycle.
  - On sr_done_i: go to DWELL.
  - If the counter reaches TIMEOUT_CYCLES before done: set fault_o and go to DWELL anyway, so the scan never stalls.
  - sr_done_i is ignored in every other state.
- DWELL:
  - Phase counter 0..7; each phase lasts PHASE_CYCLES clocks.
  - blank_o = (phase > active brightness). At brightness 7 blank_o is never high in DWELL.
  - After the final clock of phase 7:
    - digit_sel_o increments modulo 4.
    - If it wraps from 3 to 0, frame_done_o = 1 for exactly that cycle.
    - Go to LOAD.
- Output stability:
  - digit_code_o, digit_sel_o and colon_o change only in LOAD, so they are stable through START, SHIFT and DWELL.
  - brightness_i and frame inputs have effect only via the pending buffer at a frame boundary.
- Timing per digit slot: 1 + 1 + shift latency + 8*PHASE_CYCLES clocks.
- Counter widths: sized with $clog2 of the parameters; no overflow permitted. Counters clear on each state entry.

Test Plan (PHASE_CYCLES = 4, TIMEOUT_CYCLES = 16; engine model pulses sr_done_i 3 cycles after sr_start_o):
1. Reset release with no load → sr_start_o pulses; digit_code_o = 10 on all 4 digits; digit_sel_o sequence 0,1,2,3,0; blank_o stays 0 for 32 dwell clocks (brightness 7); frame_done_o pulses once per 4 slots.
2. Load digits 0x1234, colon = 1, brightness = 7 mid-frame at digit 2 → digits 2 and 3 still show 10; next frame shows codes 4,3,2,1 for sel 0..3; colon_o = 1.
3. Brightness 1 loaded → in each DWELL, blank_o = 0 for 8 clocks then 1 for 24 clocks; brightness 0 → 4 on / 28 off.
4. Two loads in one frame (0x1111, then 0x5678) plus a load coincident with the LOAD cycle at sel 0 → last value before the boundary is shown; the coincident value appears one frame later.
5. Engine model never returns done → after 16 SHIFT clocks fault_o = 1 and stays 1; the scan continues with correct digit_sel_o stepping.
6. rst_n asserted in the middle of DWELL of digit 2 → outputs go to reset values without waiting for clk; after release, the scan restarts at sel 0 with blank digits.

Source files
------------

// File: rtl/disp_refresh_sequencer.sv
// Refresh scheduler for a 4-digit 7-segment display driven through a 74HC595 chain.
// Double-buffers the frame, sequences one shift per digit, then dwells with PWM blanking.
module disp_refresh_sequencer #(
   parameter int unsigned PHASE_CYCLES   = 1250,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_load_i,
   input  logic [15:0] frame_digits_i,
   input  logic        frame_colon_i,
   input  logic [2:0]  brightness_i,
   input  logic        sr_done_i,
   output logic        sr_start_o,
   output logic [3:0]  digit_code_o,
   output logic [1:0]  digit_sel_o,
   output logic        colon_o,
   output logic        blank_o,
   output logic        frame_done_o,
   output logic        fault_o
);

   localparam int unsigned PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_START,
      ST_SHIFT,
      ST_DWELL
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [15:0]       act_digits_q, act_digits_d;
   logic              act_colon_q, act_colon_d;
   logic [2:0]        act_bright_q, act_bright_d;
   logic [15:0]       pend_digits_q, pend_digits_d;
   logic              pend_colon_q, pend_colon_d;
   logic [2:0]        pend_bright_q, pend_bright_d;
   logic              pend_valid_q, pend_valid_d;
   logic [2:0]        phase_q, phase_d;
   logic [PH_W-1:0]   cyc_q, cyc_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [3:0]        code_q, code_d;
   logic              colon_q, colon_d;
   logic              blank_q, blank_d;
   logic              start_q, start_d;
   logic              done_q, done_d;
   logic              fault_q, fault_d;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_LOAD;
         sel_q         <= 2'd0;
         act_digits_q  <= 16'hAAAA;
         act_colon_q   <= 1'b0;
         act_bright_q  <= 3'd7;
         pend_digits_q <= 16'hAAAA;
         pend_colon_q  <= 1'b0;
         pend_bright_q <= 3'd7;
         pend_valid_q  <= 1'b0;
         phase_q       <= 3'd0;
         cyc_q         <= '0;
         to_q          <= '0;
         code_q        <= 4'd10;
         colon_q       <= 1'b0;
         blank_q       <= 1'b1;
         start_q       <= 1'b0;
         done_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         act_digits_q  <= act_digits_d;
         act_colon_q   <= act_colon_d;
         act_bright_q  <= act_bright_d;
         pend_digits_q <= pend_digits_d;
         pend_colon_q  <= pend_colon_d;
         pend_bright_q <= pend_bright_d;
         pend_valid_q  <= pend_valid_d;
         phase_q       <= phase_d;
         cyc_q         <= cyc_d;
         to_q          <= to_d;
         code_q        <= code_d;
         colon_q       <= colon_d;
         blank_q       <= blank_d;
         start_q       <= start_d;
         done_q        <= done_d;
         fault_q       <= fault_d;
      end
   end

   // Next-state logic; outputs are computed for the state being entered
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      act_digits_d  = act_digits_q;
      act_colon_d   = act_colon_q;
      act_bright_d  = act_bright_q;
      pend_digits_d = pend_digits_q;
      pend_colon_d  = pend_colon_q;
      pend_bright_d = pend_bright_q;
      pend_valid_d  = pend_valid_q;
      phase_d       = phase_q;
      cyc_d         = cyc_q;
      to_d          = to_q;
      code_d        = code_q;
      colon_d       = colon_q;
      blank_d       = 1'b1;
      start_d       = 1'b0;
      done_d        = 1'b0;
      fault_d       = fault_q;

      case (state_q)
         ST_LOAD: begin
            if ((sel_q == 2'd0) && pend_valid_q) begin
               act_digits_d = pend_digits_q;
               act_colon_d  = pend_colon_q;
               act_bright_d = pend_bright_q;
               pend_valid_d = 1'b0;
            end
            code_d  = act_digits_d[{sel_q, 2'b00} +: 4];
            colon_d = act_colon_d;
            start_d = 1'b1;
            state_d = ST_START;
         end
         ST_START: begin
            to_d    = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (sr_done_i) begin
               phase_d = 3'd0;
               cyc_d   = '0;
               state_d = ST_DWELL;
            end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               // Give up on the engine but keep scanning
               fault_d = 1'b1;
               phase_d = 3'd0;
               cyc_d   = '0;
               state_d = ST_DWELL;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         ST_DWELL: begin
            if (cyc_q == PH_W'(PHASE_CYCLES - 1)) begin
               cyc_d = '0;
               if (phase_q == 3'd7) begin
                  phase_d = 3'd0;
                  sel_d   = sel_q + 2'd1;
                  done_d  = (sel_q == 2'd3);
                  state_d = ST_LOAD;
               end else begin
                  phase_d = phase_q + 3'd1;
               end
            end else begin
               cyc_d = cyc_q + PH_W'(1);
            end
         end
         default: state_d = ST_LOAD;
      endcase

      // A load in the boundary LOAD cycle lands after the copy above
      if (frame_load_i) begin
         pend_digits_d = frame_digits_i;
         pend_colon_d  = frame_colon_i;
         pend_bright_d = brightness_i;
         pend_valid_d  = 1'b1;
      end

      if (state_d == ST_DWELL) begin
         blank_d = (phase_d > act_bright_q);
      end
   end

   assign sr_start_o   = start_q;
   assign digit_code_o = code_q;
   assign digit_sel_o  = sel_q;
   assign colon_o      = colon_q;
   assign blank_o      = blank_q;
   assign frame_done_o = done_q;
   assign fault_o      = fault_q;

endmodule

// File: tb/tb_disp_refresh_sequencer.sv
// Bench for disp_refresh_sequencer: directed slot table, timeout and async-reset
// sequences, then randomized frame loads against a slot-level reference model.
module tb_disp_refresh_sequencer;

   localparam int unsigned PH    = 4;
   localparam int unsigned TO    = 16;
   localparam int unsigned DWELL = 8 * PH;
   localparam int unsigned LAT   = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_load_i;
   logic [15:0] frame_digits_i;
   logic        frame_colon_i;
   logic [2:0]  brightness_i;
   logic        sr_done_i;
   logic        sr_start_o;
   logic [3:0]  digit_code_o;
   logic [1:0]  digit_sel_o;
   logic        colon_o;
   logic        blank_o;
   logic        frame_done_o;
   logic        fault_o;

   int checks = 0;
   int errors = 0;

   disp_refresh_sequencer #(.PHASE_CYCLES(PH), .TIMEOUT_CYCLES(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .frame_load_i   (frame_load_i),
      .frame_digits_i (frame_digits_i),
      .frame_colon_i  (frame_colon_i),
      .brightness_i   (brightness_i),
      .sr_done_i      (sr_done_i),
      .sr_start_o     (sr_start_o),
      .digit_code_o   (digit_code_o),
      .digit_sel_o    (digit_sel_o),
      .colon_o        (colon_o),
      .blank_o        (blank_o),
      .frame_done_o   (frame_done_o),
      .fault_o        (fault_o)
   );

   always #5 clk = ~clk;

   // Shift-engine model: done pulse LAT cycles after each start unless dead
   logic       engine_dead = 1'b0;
   logic [2:0] eng_q = 3'b000;
   always @(posedge clk) eng_q <= {eng_q[1:0], sr_start_o & ~engine_dead};
   assign sr_done_i = eng_q[LAT-1];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One digit slot, START through the following LOAD cycle; ld=1 loads in
   // DWELL cycle ld_at, ld=2 loads during the trailing LOAD cycle.
   task automatic run_slot(input int sel, input int code, input int col, input int br,
                           input int shift_len, input int flt, input int ld, input int ld_at,
                           input logic [15:0] ld_d, input logic ld_c, input logic [2:0] ld_b);
      int n;
      n = 0;
      while (!sr_start_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("start_seen", int'(sr_start_o), 1);
      chk("sel", int'(digit_sel_o), sel);
      chk("code", int'(digit_code_o), code);
      chk("colon", int'(colon_o), col);
      chk("start_blank", int'(blank_o), 1);
      for (int i = 0; i < shift_len; i++) begin
         @(negedge clk);
         if (i == 0) chk("start_one_cycle", int'(sr_start_o), 0);
         chk("shift_blank", int'(blank_o), 1);
      end
      for (int i = 0; i < int'(DWELL); i++) begin
         @(negedge clk);
         chk("dwell_blank", int'(blank_o), ((i / int'(PH)) > br) ? 1 : 0);
         if (i == 0) chk("fault", int'(fault_o), flt);
         if (ld == 1 && i == ld_at) begin
            frame_load_i   = 1'b1;
            frame_digits_i = ld_d;
            frame_colon_i  = ld_c;
            brightness_i   = ld_b;
         end else begin
            frame_load_i   = 1'b0;
            frame_digits_i = 16'($urandom);
            frame_colon_i  = 1'($urandom);
            brightness_i   = 3'($urandom);
         end
      end
      chk("dwell_code_stable", int'(digit_code_o), code);
      @(negedge clk);
      frame_load_i = 1'b0;
      chk("load_blank", int'(blank_o), 1);
      chk("load_no_start", int'(sr_start_o), 0);
      chk("frame_done", int'(frame_done_o), (sel == 3) ? 1 : 0);
      chk("next_sel", int'(digit_sel_o), (sel + 1) % 4);
      if (ld == 2) begin
         frame_load_i   = 1'b1;
         frame_digits_i = ld_d;
         frame_colon_i  = ld_c;
         brightness_i   = ld_b;
         @(negedge clk);
         frame_load_i = 1'b0;
      end
   endtask

   typedef struct {
      int          sel;
      int          ld;
      int          ld_at;
      logic [15:0] ld_d;
      logic        ld_c;
      logic [2:0]  ld_b;
      int          code;
      int          colon;
      int          br;
   } vec_t;

   function automatic vec_t mk(int sel, int ld, int ld_at, logic [15:0] d, logic c,
                               logic [2:0] b, int code, int colon, int br);
      vec_t v;
      v.sel = sel; v.ld = ld; v.ld_at = ld_at; v.ld_d = d; v.ld_c = c; v.ld_b = b;
      v.code = code; v.colon = colon; v.br = br;
      return v;
   endfunction

   vec_t tbl[24];

   // Reference model state for the random phase
   logic [15:0] m_act_d, m_pend_d;
   logic        m_act_c, m_pend_c;
   logic [2:0]  m_act_b, m_pend_b;
   bit          m_pend_v;

   initial begin
      int          n;
      int          ld;
      int          ld_at;
      logic [15:0] rd;
      logic        rc;
      logic [2:0]  rb;

      // Frame 0: blank; load 0x1234 mid-frame at digit 2
      tbl[0]  = mk(0, 0, 0, 16'h0,    1'b0, 3'd0, 10, 0, 7);
      tbl[1]  = mk(1, 0, 0, 16'h0,    1'b0, 3'd0, 10, 0, 7);
      tbl[2]  = mk(2, 1, 5, 16'h1234, 1'b1, 3'd7, 10, 0, 7);
      tbl[3]  = mk(3, 0, 0, 16'h0,    1'b0, 3'd0, 10, 0, 7);
      // Frame 1: 4,3,2,1 full; brightness 1 loaded
      tbl[4]  = mk(0, 0, 0, 16'h0,    1'b0, 3'd0, 4, 1, 7);
      tbl[5]  = mk(1, 1, 20, 16'h1234, 1'b1, 3'd1, 3, 1, 7);
      tbl[6]  = mk(2, 0, 0, 16'h0,    1'b0, 3'd0, 2, 1, 7);
      tbl[7]  = mk(3, 0, 0, 16'h0,    1'b0, 3'd0, 1, 1, 7);
      // Frame 2: brightness 1; brightness 0 loaded on the last dwell clock
      tbl[8]  = mk(0, 0, 0, 16'h0,    1'b0, 3'd0, 4, 1, 1);
      tbl[9]  = mk(1, 0, 0, 16'h0,    1'b0, 3'd0, 3, 1, 1);
      tbl[10] = mk(2, 0, 0, 16'h0,    1'b0, 3'd0, 2, 1, 1);
      tbl[11] = mk(3, 1, 31, 16'h1234, 1'b1, 3'd0, 1, 1, 1);
      // Frame 3: brightness 0; two loads then a coincident boundary load
      tbl[12] = mk(0, 1, 3, 16'h1111, 1'b0, 3'd7, 4, 1, 0);
      tbl[13] = mk(1, 0, 0, 16'h0,    1'b0, 3'd0, 3, 1, 0);
      tbl[14] = mk(2, 1, 10, 16'h5678, 1'b0, 3'd7, 2, 1, 0);
      tbl[15] = mk(3, 2, 0, 16'h9876, 1'b1, 3'd3, 1, 1, 0);
      // Frame 4: last pre-boundary value
      tbl[16] = mk(0, 0, 0, 16'h0,    1'b0, 3'd0, 8, 0, 7);
      tbl[17] = mk(1, 0, 0, 16'h0,    1'b0, 3'd0, 7, 0, 7);
      tbl[18] = mk(2, 0, 0, 16'h0,    1'b0, 3'd0, 6, 0, 7);
      tbl[19] = mk(3, 0, 0, 16'h0,    1'b0, 3'd0, 5, 0, 7);
      // Frame 5: coincident load one frame later
      tbl[20] = mk(0, 0, 0, 16'h0,    1'b0, 3'd0, 6, 1, 3);
      tbl[21] = mk(1, 0, 0, 16'h0,    1'b0, 3'd0, 7, 1, 3);
      tbl[22] = mk(2, 0, 0, 16'h0,    1'b0, 3'd0, 8, 1, 3);
      tbl[23] = mk(3, 0, 0, 16'h0,    1'b0, 3'd0, 9, 1, 3);

      rst_n          = 1'b0;
      frame_load_i   = 1'b0;
      frame_digits_i = 16'h0;
      frame_colon_i  = 1'b0;
      brightness_i   = 3'd0;
      repeat (2) @(negedge clk);
      chk("rst_start", int'(sr_start_o), 0);
      chk("rst_code", int'(digit_code_o), 10);
      chk("rst_sel", int'(digit_sel_o), 0);
      chk("rst_blank", int'(blank_o), 1);
      chk("rst_fault", int'(fault_o), 0);
      rst_n = 1'b1;

      for (int k = 0; k < 24; k++) begin
         run_slot(tbl[k].sel, tbl[k].code, tbl[k].colon, tbl[k].br, int'(LAT), 0,
                  tbl[k].ld, tbl[k].ld_at, tbl[k].ld_d, tbl[k].ld_c, tbl[k].ld_b);
      end

      // Dead engine: every shift times out, fault sticks, scan keeps stepping
      engine_dead = 1'b1;
      for (int s = 0; s < 4; s++) begin
         run_slot(s, 6 + s, 1, 3, int'(TO), 1, 0, 0, 16'h0, 1'b0, 3'd0);
      end
      engine_dead = 1'b0;
      run_slot(0, 6, 1, 3, int'(LAT), 1, 0, 0, 16'h0, 1'b0, 3'd0);
      run_slot(1, 7, 1, 3, int'(LAT), 1, 0, 0, 16'h0, 1'b0, 3'd0);

      // Async reset mid-dwell of digit 2
      n = 0;
      while (!sr_start_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_sel", int'(digit_sel_o), 2);
      repeat (LAT + 10) @(negedge clk);
      chk("pre_rst_blank", int'(blank_o), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_code", int'(digit_code_o), 10);
      chk("async_rst_sel", int'(digit_sel_o), 0);
      chk("async_rst_colon", int'(colon_o), 0);
      chk("async_rst_blank", int'(blank_o), 1);
      chk("async_rst_fault", int'(fault_o), 0);
      chk("async_rst_done", int'(frame_done_o), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Random loads against the frame-level model
      m_act_d = 16'hAAAA; m_act_c = 1'b0; m_act_b = 3'd7;
      m_pend_d = 16'hAAAA; m_pend_c = 1'b0; m_pend_b = 3'd7; m_pend_v = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if ((k % 4) == 0 && m_pend_v) begin
            m_act_d = m_pend_d; m_act_c = m_pend_c; m_act_b = m_pend_b;
            m_pend_v = 1'b0;
         end
         ld    = ($urandom_range(0, 1) == 0) ? 1 : 0;
         ld_at = int'($urandom_range(0, DWELL - 1));
         for (int d = 0; d < 4; d++) rd[d*4 +: 4] = 4'($urandom_range(0, 10));
         rc = 1'($urandom);
         rb = 3'($urandom);
         run_slot(k % 4, int'(m_act_d[(k % 4) * 4 +: 4]), int'(m_act_c), int'(m_act_b),
                  int'(LAT), 0, ld, ld_at, rd, rc, rb);
         if (ld == 1) begin
            m_pend_d = rd; m_pend_c = rc; m_pend_b = rb; m_pend_v = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
